// File: rtl/sm_alu_pkg.sv
// Shared types for the sequential sign-magnitude arithmetic unit.
package sm_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CMP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

endpackage

// File: rtl/sm_addsub_comb.sv
// Combinational sign-magnitude add/sub with signed compare and zero normalisation.
module sm_addsub_comb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] am,
  input  logic [WIDTH-1:0] bm,
  input  logic             as,
  input  logic             bs,
  input  logic             b_inv,
  output logic [WIDTH-1:0] ym,
  output logic             ys,
  output logic             carry,
  output logic             equal,
  output logic             lessthan
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mag;
  logic             bs_eff;
  logic             sign;
  logic             both_zero;

  always_comb begin
    bs_eff = bs ^ b_inv;
    sum    = {1'b0, am} + {1'b0, bm};
    mag    = '0;
    sign   = 1'b0;
    carry  = 1'b0;
    if (as == bs_eff) begin
      mag   = sum[WIDTH-1:0];
      carry = sum[WIDTH];
      sign  = as;
    end else if (am >= bm) begin
      mag  = am - bm;
      sign = as;
    end else begin
      mag  = bm - am;
      sign = bs_eff;
    end
    ym = mag;
    ys = sign & (|mag);
  end

  // Comparison always uses the operand signs as given, never the inverted subtrahend.
  always_comb begin
    both_zero = (am == '0) && (bm == '0);
    equal     = both_zero || ((am == bm) && (as == bs));
    lessthan  = 1'b0;
    if (!both_zero) begin
      if (as != bs)
        lessthan = as;
      else if (as)
        lessthan = am > bm;
      else
        lessthan = am < bm;
    end
  end

endmodule

// File: rtl/sm_alu_seq.sv
// Multi-cycle sign-magnitude ALU: add/sub/cmp in one cycle, shift-add multiply over WIDTH cycles.
module sm_alu_seq
  import sm_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] am,
  input  logic [WIDTH-1:0] bm,
  input  logic             as,
  input  logic             bs,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ym,
  output logic             ys,
  output logic             of,
  output logic             equal,
  output logic             lessthan
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t state, state_next;
  op_t    op_in, op_r, op_sel;

  logic [WIDTH-1:0]   am_r, bm_r, am_sel, bm_sel;
  logic               as_r, bs_r, as_sel, bs_sel;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH:0]     hi_sum;
  logic [CW-1:0]      cnt;
  logic               idle, accept, mul_last, load_res;

  logic [WIDTH-1:0] as_ym;
  logic             as_ys, as_carry, cmp_eq, cmp_lt;

  assign op_in    = op_t'(op);
  assign idle     = (state == S_IDLE);
  assign accept   = idle && start;
  assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
  assign load_res = (accept && (op_in != OP_MUL)) || mul_last;

  // Single-cycle ops write results on the accept edge, so the comb path sees live inputs while idle.
  assign op_sel = idle ? op_in : op_r;
  assign am_sel = idle ? am    : am_r;
  assign bm_sel = idle ? bm    : bm_r;
  assign as_sel = idle ? as    : as_r;
  assign bs_sel = idle ? bs    : bs_r;

  sm_addsub_comb #(.WIDTH(WIDTH)) u_addsub (
    .am       (am_sel),
    .bm       (bm_sel),
    .as       (as_sel),
    .bs       (bs_sel),
    .b_inv    (op_sel == OP_SUB),
    .ym       (as_ym),
    .ys       (as_ys),
    .carry    (as_carry),
    .equal    (cmp_eq),
    .lessthan (cmp_lt)
  );

  // Upper half accumulates, lower half holds the remaining multiplier bits.
  always_comb begin
    hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, am_r & {WIDTH{acc[0]}}};
    acc_next = {hi_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (op_in == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:   if (mul_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= OP_ADD;
      am_r     <= '0;
      bm_r     <= '0;
      as_r     <= 1'b0;
      bs_r     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      ym       <= '0;
      ys       <= 1'b0;
      of       <= 1'b0;
      equal    <= 1'b0;
      lessthan <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= op_in;
        am_r <= am;
        bm_r <= bm;
        as_r <= as;
        bs_r <= bs;
        acc  <= {{WIDTH{1'b0}}, bm};
        cnt  <= '0;
      end else if (state == S_MUL) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
      end
      if (load_res) begin
        equal    <= cmp_eq;
        lessthan <= cmp_lt;
        case (op_sel)
          OP_MUL: begin
            ym <= acc_next[WIDTH-1:0];
            ys <= (as_r ^ bs_r) & (|acc_next[WIDTH-1:0]);
            of <= |acc_next[2*WIDTH-1:WIDTH];
          end
          OP_CMP: begin
            ym <= '0;
            ys <= 1'b0;
            of <= 1'b0;
          end
          default: begin
            ym <= as_ym;
            ys <= as_ys;
            of <= as_carry;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_alu_seq.sv
// Directed bench for sm_alu_seq with a signed-integer reference model checked every cycle.
module tb_sm_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] am, bm;
  logic         as, bs;
  logic         busy, done;
  logic [W-1:0] ym;
  logic         ys, of, equal, lessthan;

  int n_checks = 0;
  int n_fail   = 0;

  sm_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .am       (am),
    .bm       (bm),
    .as       (as),
    .bs       (bs),
    .busy     (busy),
    .done     (done),
    .ym       (ym),
    .ys       (ys),
    .of       (of),
    .equal    (equal),
    .lessthan (lessthan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycle index, pending result, and the cycle in which done is due.
  int n = 0;
  bit active = 0;
  int done_cyc = 0;
  int p_ym, p_ys, p_of, p_eq, p_lt;
  int exp_ym = 0, exp_ys = 0, exp_of = 0, exp_eq = 0, exp_lt = 0;
  int ma, mb, mr, mmag;
  bit was_busy;

  always @(posedge clk) begin
    was_busy = active && (n <= done_cyc);
    n++;
    if (reset) begin
      active = 0;
      exp_ym = 0; exp_ys = 0; exp_of = 0; exp_eq = 0; exp_lt = 0;
    end else begin
      if (!was_busy && start) begin
        ma = as ? -int'(am) : int'(am);
        mb = bs ? -int'(bm) : int'(bm);
        p_eq = (ma == mb) ? 1 : 0;
        p_lt = (ma < mb) ? 1 : 0;
        case (op)
          2'b00:   mr = ma + mb;
          2'b01:   mr = ma - mb;
          2'b10:   mr = (as ^ bs) ? -(int'(am) * int'(bm)) : int'(am) * int'(bm);
          default: mr = 0;
        endcase
        mmag = (mr < 0) ? -mr : mr;
        p_ym = mmag % (1 << W);
        p_of = (mmag >= (1 << W)) ? 1 : 0;
        p_ys = (mr < 0 && p_ym != 0) ? 1 : 0;
        active   = 1;
        done_cyc = n + ((op == 2'b10) ? W : 0);
      end
      if (active && n == done_cyc) begin
        exp_ym = p_ym; exp_ys = p_ys; exp_of = p_of; exp_eq = p_eq; exp_lt = p_lt;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",     busy,     int'(active && n <= done_cyc));
    chk("done",     done,     int'(active && n == done_cyc));
    chk("ym",       ym,       exp_ym);
    chk("ys",       ys,       exp_ys);
    chk("of",       of,       exp_of);
    chk("equal",    equal,    exp_eq);
    chk("lessthan", lessthan, exp_lt);
  end

  task automatic run(input string nm, input logic [1:0] o, input logic sa, input int xa,
                     input logic sb, input int xb, input int e_lat, input int e_ym,
                     input int e_ys, input int e_of, input int e_eq, input int e_lt);
    int lat, bcnt;
    @(negedge clk);
    op = o; as = sa; am = W'(xa); bs = sb; bm = W'(xb); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    chk({nm, "_latency"}, lat, e_lat);
    chk({nm, "_busycyc"}, bcnt, e_lat);
    chk({nm, "_ym"}, ym, e_ym);
    chk({nm, "_ys"}, ys, e_ys);
    chk({nm, "_of"}, of, e_of);
    chk({nm, "_equal"}, equal, e_eq);
    chk({nm, "_lessthan"}, lessthan, e_lt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00;
    am = '0; bm = '0; as = 1'b0; bs = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ym", ym, 0);
    chk("rst_flags", {ys, of, equal, lessthan}, 0);
    reset = 1'b0;

    //   name        op     as  am    bs  bm   lat ym  ys of eq lt
    run("add_p5_m3",  2'b00, 0,   5,  1,   3,  1,   2, 0, 0, 0, 0);
    run("add_ovf",    2'b00, 0, 200,  0, 100,  1,  44, 0, 1, 0, 0);
    run("sub_m7_m7",  2'b01, 1,   7,  1,   7,  1,   0, 0, 0, 1, 0);
    run("mul_m12_11", 2'b10, 1,  12,  0,  11,  9, 132, 1, 0, 0, 1);
    run("mul_16_m16", 2'b10, 0,  16,  1,  16,  9,   0, 0, 1, 0, 0);
    run("cmp_m0_p0",  2'b11, 1,   0,  0,   0,  1,   0, 0, 0, 1, 0);
    run("cmp_m3_p2",  2'b11, 1,   3,  0,   2,  1,   0, 0, 0, 0, 1);
    run("cmp_m9_m4",  2'b11, 1,   9,  1,   4,  1,   0, 0, 0, 0, 1);
    run("add_m0_m0",  2'b00, 1,   0,  1,   0,  1,   0, 0, 0, 1, 0);
    run("sub_3_10",   2'b01, 0,   3,  0,  10,  1,   7, 1, 0, 0, 1);
    run("add_neg_of", 2'b00, 1, 200,  1, 100,  1,  44, 1, 1, 0, 1);
    run("add_wrap0",  2'b00, 1, 128,  1, 128,  1,   0, 0, 1, 1, 0);
    run("sub_100_m50",2'b01, 0, 100,  1,  50,  1, 150, 0, 0, 0, 0);
    run("sub_ovf",    2'b01, 0, 200,  1, 100,  1,  44, 0, 1, 0, 0);
    run("mul_max",    2'b10, 0, 255,  0, 255,  9,   1, 0, 1, 1, 0);
    run("mul_zero",   2'b10, 0,   0,  1,   5,  9,   0, 0, 0, 0, 0);

    // Restarts during a multiply (including its DONE cycle) must be ignored.
    @(negedge clk);
    op = 2'b10; as = 1'b1; am = 8'd12; bs = 1'b0; bm = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 14; i++) begin
      if (done) begin
        dones++;
        chk("ign_ym", ym, 132);
        chk("ign_ys", ys, 1);
        chk("ign_cycle", i, 9);
      end
      if (i == 3) begin
        op = 2'b00; as = 1'b0; am = 8'd50; bs = 1'b0; bm = 8'd3; start = 1'b1;
      end else if (i == 4) begin
        start = 1'b0;
      end else if (i == 9) begin
        op = 2'b11; am = 8'd1; bm = 8'd2; start = 1'b1;
      end else if (i == 10) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_dones", dones, 1);

    // Reset in the 4th MUL cycle abandons the multiply.
    op = 2'b10; as = 1'b0; am = 8'd7; bs = 1'b0; bm = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done, 0);
    chk("rmid_ym", ym, 0);
    chk("rmid_flags", {ys, of, equal, lessthan}, 0);
    run("add_after_rst", 2'b00, 0, 20, 1, 30, 1, 10, 1, 0, 0, 0);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rmid_no_done", dones, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
